// File: rtl/vga_overlay_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// vga_overlay_pkg
// Shared types and constants for the VGA overlay controller slice.
//   state_t      : converter FSM state (IDLE, CONV)
//   bcd_digit_t  : one BCD digit
//   MAX_VAL      : largest displayable value, larger inputs saturate to it
//   DD_ITERS     : double-dabble iterations for a 10-bit binary input
//   clamp10      : clamp a 10-bit coordinate into [lo, hi]
//   step_toward  : move a coordinate toward a target by at most 'step'
// ----------------------------------------------------------------------------
package vga_overlay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [9:0] MAX_VAL  = 10'd999;
    localparam logic [3:0] DD_ITERS = 4'd10;

    function automatic logic [9:0] clamp10(input logic [9:0] v,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    function automatic logic [9:0] step_toward(input logic [9:0] cur,
                                               input logic [9:0] tgt,
                                               input logic [9:0] step);
        if (tgt > cur) return ((tgt - cur) > step) ? (cur + step) : tgt;
        else           return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/vga_overlay_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_overlay_ctrl_if
// Groups the upstream value handshake and marker position update signals.
//   val_in/val_valid/val_ready : binary value 0..999 with valid/ready
//   pos_x_in/pos_y_in/pos_valid: requested marker position, no backpressure
// master drives requests, slave (the controller) returns val_ready.
// ----------------------------------------------------------------------------
interface vga_overlay_ctrl_if;
    logic [9:0] val_in;
    logic       val_valid;
    logic       val_ready;
    logic [9:0] pos_x_in;
    logic [9:0] pos_y_in;
    logic       pos_valid;

    modport master (
        output val_in, val_valid, pos_x_in, pos_y_in, pos_valid,
        input  val_ready
    );

    modport slave (
        input  val_in, val_valid, pos_x_in, pos_y_in, pos_valid,
        output val_ready
    );
endinterface

// File: rtl/vga_overlay_ctrl_bcd_dd10.sv
// ----------------------------------------------------------------------------
// bcd_dd10
// Sequential double-dabble: converts a 10-bit binary value to three BCD
// digits, one adjust+shift iteration per clock, DD_ITERS iterations.
//   clk, reset_n : clock, async active-low reset
//   start        : load bin_in and begin converting (ignored while busy)
//   bin_in       : binary value, expected <= 999
//   done         : high during the final iteration; hun/ten/one are valid
//                  in that same cycle (they show the final shifted result)
//   hun/ten/one  : BCD digits
// ----------------------------------------------------------------------------
module bcd_dd10
    import vga_overlay_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [9:0] bin_in,
    output logic       done,
    output bcd_digit_t hun,
    output bcd_digit_t ten,
    output bcd_digit_t one
);

    // {bcd[11:0], bin[9:0]} shift register
    logic [21:0] sr_q, sr_d;
    logic [3:0]  iter_q, iter_d;
    logic        busy_q, busy_d;
    logic [21:0] adj;
    logic [21:0] shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[10 + 4*i +: 4] >= 4'd5)
                adj[10 + 4*i +: 4] = adj[10 + 4*i +: 4] + 4'd3;
        end
        shifted = adj << 1;

        sr_d   = sr_q;
        iter_d = iter_q;
        busy_d = busy_q;
        if (busy_q) begin
            sr_d   = shifted;
            iter_d = iter_q + 4'd1;
            if (iter_q == DD_ITERS - 4'd1)
                busy_d = 1'b0;
        end else if (start) begin
            sr_d   = {12'd0, bin_in};
            iter_d = '0;
            busy_d = 1'b1;
        end
    end

    // Digits are taken from the in-flight shift so the result is usable in
    // the same cycle as done, saving a cycle of latency.
    assign done = busy_q && (iter_q == DD_ITERS - 4'd1);
    assign hun  = shifted[21:18];
    assign ten  = shifted[17:14];
    assign one  = shifted[13:10];

endmodule

// File: rtl/vga_overlay_ctrl.sv
// ----------------------------------------------------------------------------
// vga_overlay_ctrl
// Feeds the VGA pattern generator's overlay inputs. Values are converted to
// BCD, positions are clamped to the visible area, and everything is committed
// to the outputs only at the falling edge of vga_vs so a frame never mixes
// old and new overlay data.
// Ports:
//   clk, reset_n       : pixel clock, async active-low reset
//   bus (slave)        : val_in/val_valid/val_ready, pos_x_in/pos_y_in/pos_valid
//   vga_vs             : generator vertical sync, low during the pulse
//   point_x, point_y   : committed marker position
//   bai, shi, ge       : committed hundreds/tens/units digits
//   overflow           : committed value was saturated to 999
//   frame_commit       : one-cycle pulse on each commit
// Build option: define VGA_POS_SLEW_EN to limit marker motion to SLEW_STEP
// pixels per frame per axis; otherwise the marker jumps to its target.
// ----------------------------------------------------------------------------
module vga_overlay_ctrl
    import vga_overlay_pkg::*;
#(
    parameter int X_MIN     = 10,
    parameter int X_MAX     = 629,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 469,
    parameter int POS_X_RST = 461,
    parameter int POS_Y_RST = 190,
    parameter int SLEW_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_overlay_ctrl_if.slave    bus,
    input  logic                 vga_vs,
    output logic [9:0]           point_x,
    output logic [9:0]           point_y,
    output bcd_digit_t           bai,
    output bcd_digit_t           shi,
    output bcd_digit_t           ge,
    output logic                 overflow,
    output logic                 frame_commit
);

    if (SLEW_STEP < 1 || SLEW_STEP > 1023) begin : g_bad_slew_step
        $error("SLEW_STEP must be in 1..1023");
    end

    state_t     state_q, state_d;
    logic       sat_q, sat_d;
    logic       pending_q, pending_d;
    logic       vs_q, vs_d;
    bcd_digit_t sh_bai_q, sh_bai_d, sh_shi_q, sh_shi_d, sh_ge_q, sh_ge_d;
    logic       sh_ovf_q, sh_ovf_d;
    logic [9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [9:0] point_x_q, point_x_d, point_y_q, point_y_d;
    bcd_digit_t bai_q, bai_d, shi_q, shi_d, ge_q, ge_d;
    logic       overflow_q, overflow_d;
    logic       frame_commit_q, frame_commit_d;

    logic       strobe;
    logic       dd_start, dd_done;
    logic [9:0] dd_bin;
    bcd_digit_t dd_hun, dd_ten, dd_one;

    bcd_dd10 u_dd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (dd_start),
        .bin_in  (dd_bin),
        .done    (dd_done),
        .hun     (dd_hun),
        .ten     (dd_ten),
        .one     (dd_one)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sat_q          <= 1'b0;
            pending_q      <= 1'b0;
            vs_q           <= 1'b0;
            sh_bai_q       <= '0;
            sh_shi_q       <= '0;
            sh_ge_q        <= '0;
            sh_ovf_q       <= 1'b0;
            sh_x_q         <= 10'(POS_X_RST);
            sh_y_q         <= 10'(POS_Y_RST);
            point_x_q      <= 10'(POS_X_RST);
            point_y_q      <= 10'(POS_Y_RST);
            bai_q          <= '0;
            shi_q          <= '0;
            ge_q           <= '0;
            overflow_q     <= 1'b0;
            frame_commit_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sat_q          <= sat_d;
            pending_q      <= pending_d;
            vs_q           <= vs_d;
            sh_bai_q       <= sh_bai_d;
            sh_shi_q       <= sh_shi_d;
            sh_ge_q        <= sh_ge_d;
            sh_ovf_q       <= sh_ovf_d;
            sh_x_q         <= sh_x_d;
            sh_y_q         <= sh_y_d;
            point_x_q      <= point_x_d;
            point_y_q      <= point_y_d;
            bai_q          <= bai_d;
            shi_q          <= shi_d;
            ge_q           <= ge_d;
            overflow_q     <= overflow_d;
            frame_commit_q <= frame_commit_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sat_d          = sat_q;
        pending_d      = pending_q;
        vs_d           = vga_vs;
        sh_bai_d       = sh_bai_q;
        sh_shi_d       = sh_shi_q;
        sh_ge_d        = sh_ge_q;
        sh_ovf_d       = sh_ovf_q;
        sh_x_d         = sh_x_q;
        sh_y_d         = sh_y_q;
        point_x_d      = point_x_q;
        point_y_d      = point_y_q;
        bai_d          = bai_q;
        shi_d          = shi_q;
        ge_d           = ge_q;
        overflow_d     = overflow_q;
        frame_commit_d = 1'b0;
        dd_start       = 1'b0;
        dd_bin         = (bus.val_in > MAX_VAL) ? MAX_VAL : bus.val_in;
        strobe         = vs_q && !vga_vs;

        // Commit reads only _q shadows, so a shadow written on this same
        // edge lands in the next frame instead.
        if (strobe) begin
`ifdef VGA_POS_SLEW_EN
            point_x_d = step_toward(point_x_q, sh_x_q, 10'(SLEW_STEP));
            point_y_d = step_toward(point_y_q, sh_y_q, 10'(SLEW_STEP));
`else
            point_x_d = sh_x_q;
            point_y_d = sh_y_q;
`endif
            if (pending_q) begin
                bai_d      = sh_bai_q;
                shi_d      = sh_shi_q;
                ge_d       = sh_ge_q;
                overflow_d = sh_ovf_q;
            end
            pending_d      = 1'b0;
            frame_commit_d = 1'b1;
        end

        // Evaluated after the strobe so a completion on the strobe edge
        // keeps pending set for the following frame.
        case (state_q)
            IDLE: begin
                if (bus.val_valid) begin
                    dd_start = 1'b1;
                    sat_d    = bus.val_in > MAX_VAL;
                    state_d  = CONV;
                end
            end
            CONV: begin
                if (dd_done) begin
                    sh_bai_d  = dd_hun;
                    sh_shi_d  = dd_ten;
                    sh_ge_d   = dd_one;
                    sh_ovf_d  = sat_q;
                    pending_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.pos_valid) begin
            sh_x_d = clamp10(bus.pos_x_in, 10'(X_MIN), 10'(X_MAX));
            sh_y_d = clamp10(bus.pos_y_in, 10'(Y_MIN), 10'(Y_MAX));
        end
    end

    assign bus.val_ready = (state_q == IDLE);
    assign point_x       = point_x_q;
    assign point_y       = point_y_q;
    assign bai           = bai_q;
    assign shi           = shi_q;
    assign ge            = ge_q;
    assign overflow      = overflow_q;
    assign frame_commit  = frame_commit_q;

endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_overlay_ctrl
// Directed scoreboard bench for vga_overlay_ctrl. Each vsync pulse pushes the
// expected committed overlay; a negedge monitor pops on frame_commit and checks
// that outputs hold steady between commits.
// ----------------------------------------------------------------------------
module tb_vga_overlay_ctrl;
    import vga_overlay_pkg::*;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [3:0] b;
        logic [3:0] s;
        logic [3:0] g;
        logic       o;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       vga_vs;
    logic [9:0] point_x, point_y;
    bcd_digit_t bai, shi, ge;
    logic       overflow, frame_commit;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    exp_t cur;
    exp_t e;
    logic [9:0] mdl_x, mdl_y, tgt_x, tgt_y;

    vga_overlay_ctrl_if bus_if ();

    vga_overlay_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus_if),
        .vga_vs       (vga_vs),
        .point_x      (point_x),
        .point_y      (point_y),
        .bai          (bai),
        .shi          (shi),
        .ge           (ge),
        .overflow     (overflow),
        .frame_commit (frame_commit)
    );

    // 10 ns pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a stuck DUT can never hang the run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value, counting every comparison and every pass
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    // Expected marker motion per committed frame
    function automatic logic [9:0] nextPos(input logic [9:0] c, input logic [9:0] t);
`ifdef VGA_POS_SLEW_EN
        if (t > c) return ((t - c) > 10'd4) ? c + 10'd4 : t;
        else       return ((c - t) > 10'd4) ? c - 10'd4 : t;
`else
        return (c === 10'bx) ? t : t;
`endif
    endfunction

    // Monitor: pop and compare on each commit, otherwise outputs must hold
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_commit) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_commit: actual=commit required=none");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("commit_point_x", point_x, e.px);
                    checkOutput("commit_point_y", point_y, e.py);
                    checkOutput("commit_bai", bai, e.b);
                    checkOutput("commit_shi", shi, e.s);
                    checkOutput("commit_ge", ge, e.g);
                    checkOutput("commit_overflow", overflow, e.o);
                    cur = e;
                end
            end else begin
                checkOutput("hold_outputs", {point_x, point_y, bai, shi, ge, overflow},
                            {cur.px, cur.py, cur.b, cur.s, cur.g, cur.o});
            end
        end
    end

    // Return the expectation model to its reset state
    task automatic resetModel();
        cur   = '{10'd461, 10'd190, 4'd0, 4'd0, 4'd0, 1'b0};
        mdl_x = 10'd461;
        mdl_y = 10'd190;
        tgt_x = 10'd461;
        tgt_y = 10'd190;
    endtask

    // Wait (bounded) until the converter can accept
    task automatic waitReady();
        int n = 0;
        while (!bus_if.val_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ready_wait", bus_if.val_ready, 1);
    endtask

    // Falling vsync edge with the expected commit pushed to the scoreboard
    task automatic vsPulse(input logic [3:0] b, input logic [3:0] s,
                           input logic [3:0] g, input logic o);
        @(posedge clk); #1;
        mdl_x = nextPos(mdl_x, tgt_x);
        mdl_y = nextPos(mdl_y, tgt_y);
        sb_q.push_back('{mdl_x, mdl_y, b, s, g, o});
        vga_vs = 1'b0;
        repeat (4) @(posedge clk);
        #1 vga_vs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Single-cycle position write; cx/cy are the hand-clamped targets
    task automatic setPos(input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] cx, input logic [9:0] cy);
        @(posedge clk); #1;
        bus_if.pos_x_in  = x;
        bus_if.pos_y_in  = y;
        bus_if.pos_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.pos_valid = 1'b0;
        tgt_x = cx;
        tgt_y = cy;
    endtask

    // Send one value and check val_ready through the conversion; a junk
    // value is held valid during CONV and must be ignored
    task automatic sendVal(input logic [9:0] v);
        @(posedge clk); #1;
        waitReady();
        bus_if.val_in    = v;
        bus_if.val_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.val_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checkOutput($sformatf("val_ready_cycle%0d", k), bus_if.val_ready, 0);
            if (k == 1) begin
                bus_if.val_in    = 10'd123;
                bus_if.val_valid = 1'b1;
            end
            if (k == 10) bus_if.val_valid = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("val_ready_cycle11", bus_if.val_ready, 1);
    endtask

    // Conversion finishing on the very strobe edge: old digits commit now
    task automatic convStrobe(input logic [9:0] v, input logic [3:0] b,
                              input logic [3:0] s, input logic [3:0] g,
                              input logic o);
        @(posedge clk); #1;
        waitReady();
        bus_if.val_in    = v;
        bus_if.val_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.val_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        mdl_x = nextPos(mdl_x, tgt_x);
        mdl_y = nextPos(mdl_y, tgt_y);
        sb_q.push_back('{mdl_x, mdl_y, b, s, g, o});
        vga_vs = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_strobe_done", bus_if.val_ready, 1);
        repeat (3) @(posedge clk);
        #1 vga_vs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Position write on the strobe edge itself: old target commits now
    task automatic posStrobe(input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] b, input logic [3:0] s,
                             input logic [3:0] g, input logic o);
        @(posedge clk); #1;
        mdl_x = nextPos(mdl_x, tgt_x);
        mdl_y = nextPos(mdl_y, tgt_y);
        sb_q.push_back('{mdl_x, mdl_y, b, s, g, o});
        vga_vs           = 1'b0;
        bus_if.pos_x_in  = x;
        bus_if.pos_y_in  = y;
        bus_if.pos_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.pos_valid = 1'b0;
        tgt_x = x;
        tgt_y = y;
        repeat (3) @(posedge clk);
        #1 vga_vs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Whole directed sequence
    task automatic applyStimulus();
        // reset values
        checkOutput("reset_point_x", point_x, 461);
        checkOutput("reset_point_y", point_y, 190);
        checkOutput("reset_bai", bai, 0);
        checkOutput("reset_shi", shi, 0);
        checkOutput("reset_ge", ge, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_frame_commit", frame_commit, 0);
        checkOutput("reset_val_ready", bus_if.val_ready, 1);

        // idle frame commits reset contents
        vsPulse(4'd0, 4'd0, 4'd0, 1'b0);

        // marker move 461 -> 470 over three frames
        setPos(10'd470, 10'd190, 10'd470, 10'd190);
        vsPulse(4'd0, 4'd0, 4'd0, 1'b0);
        vsPulse(4'd0, 4'd0, 4'd0, 1'b0);
        vsPulse(4'd0, 4'd0, 4'd0, 1'b0);

        // conversions
        sendVal(10'd360);
        vsPulse(4'd3, 4'd6, 4'd0, 1'b0);
        sendVal(10'd1023);
        vsPulse(4'd9, 4'd9, 4'd9, 1'b1);
        sendVal(10'd7);
        vsPulse(4'd0, 4'd0, 4'd7, 1'b0);

        // clamping, latest write wins
        setPos(10'd700, 10'd2, 10'd629, 10'd10);
        setPos(10'd100, 10'd200, 10'd100, 10'd200);
        vsPulse(4'd0, 4'd0, 4'd7, 1'b0);
        setPos(10'd700, 10'd2, 10'd629, 10'd10);
        vsPulse(4'd0, 4'd0, 4'd7, 1'b0);
        setPos(10'd5, 10'd900, 10'd10, 10'd469);
        vsPulse(4'd0, 4'd0, 4'd7, 1'b0);

        // completion coincident with strobe
        convStrobe(10'd58, 4'd0, 4'd0, 4'd7, 1'b0);
        vsPulse(4'd0, 4'd5, 4'd8, 1'b0);

        // position write coincident with strobe
        posStrobe(10'd300, 10'd300, 4'd0, 4'd5, 4'd8, 1'b0);
        vsPulse(4'd0, 4'd5, 4'd8, 1'b0);

        // reset in the middle of a conversion discards it
        @(posedge clk); #1;
        waitReady();
        bus_if.val_in    = 10'd512;
        bus_if.val_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.val_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        checkOutput("val_ready_after_reset", bus_if.val_ready, 1);
        checkOutput("point_x_after_reset", point_x, 461);
        vsPulse(4'd0, 4'd0, 4'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no_stale_commit", bai, 0);
    endtask

    // Main: reset, run the sequence, settle, drain check, summary
    initial begin
        reset_n          = 1'b0;
        vga_vs           = 1'b1;
        bus_if.val_in    = '0;
        bus_if.val_valid = 1'b0;
        bus_if.pos_x_in  = '0;
        bus_if.pos_y_in  = '0;
        bus_if.pos_valid = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_overlay_ctrl.md
Name: vga_overlay_ctrl

Overview:
Upstream feeder of the VGA pattern generator's overlay inputs: marker position (point_x/point_y) and three decimal digits (bai/shi/ge).
- Accepts a binary value 0..999 over a valid/ready handshake and converts it to BCD with a sequential double-dabble.
- Captures marker position updates and clamps them to the visible area.
- Commits all overlay registers only at the start of vertical sync, so a frame never shows a mix of old and new values.

Parameters:
X_MIN, 10, lowest legal point_x (keeps point_x-10 non-negative in generator)
X_MAX, 629, highest legal point_x
Y_MIN, 10, lowest legal point_y
Y_MAX, 469, highest legal point_y
POS_X_RST, 461, point_x after reset
POS_Y_RST, 190, point_y after reset
SLEW_STEP, 4, max pixels moved per frame per axis (only with VGA_POS_SLEW_EN)

Ports:
clk  in  1  pixel clock, same domain as generator
reset_n  in  1  asynchronous, active-low reset
val_in  in  10  binary value to display
val_valid  in  1  val_in valid
val_ready  out  1  converter idle, can accept
pos_x_in  in  10  requested marker x
pos_y_in  in  10  requested marker y
pos_valid  in  1  pos_x_in/pos_y_in valid (no backpressure)
vga_vs  in  1  generator vertical sync (low during sync pulse)
point_x  out  10  committed marker x
point_y  out  10  committed marker y
bai  out  4  committed hundreds digit
shi  out  4  committed tens digit
ge  out  4  committed units digit
overflow  out  1  committed value was saturated
frame_commit  out  1  one-cycle pulse on each commit

Behaviour:
- Reset: point_x=POS_X_RST, point_y=POS_Y_RST, bai=shi=ge=0, overflow=0, frame_commit=0, val_ready=1, FSM=IDLE, pending=0, all shadows equal to outputs. Reset mid-conversion aborts the conversion and discards the value.
- FSM IDLE/CONV; val_ready = (state==IDLE), combinational from state.
  - Accept when val_valid && val_ready (cycle 0). If val_in>999, load 999 and set sat flag; otherwise load val_in and clear sat.
  - CONV runs exactly 10 iterations (cycles 1..10). Each iteration: add 3 to every BCD nibble >=5, then shift left one bit.
  - End of cycle 10: write digits and sat into the value shadow, set pending, return to IDLE. val_ready=1 in cycle 11.
  - Total accept-to-shadow latency is 11 cycles. Any input presented during CONV is not accepted.
- Position shadow: on any cycle with pos_valid, store clamp(pos_x_in,X_MIN,X_MAX) and clamp(pos_y_in,Y_MIN,Y_MAX). Latest write wins; no handshake.
- Frame strobe: vs_d registers vga_vs; strobe = vs_d && !vga_vs (falling edge).
- On strobe, registered in the same edge:
  - Outputs load the value shadow (if pending) and the position shadow.
  - frame_commit=1 for that one cycle; pending clears.
- Simultaneous strobe and conversion completion: commit uses the shadow contents from before that edge. The new result stays pending for the next frame, and pending stays set.
- Simultaneous strobe and pos_valid: commit uses the old position shadow; the new position commits next frame.
- Outputs never change except on a strobe edge (or reset).

Optional Feature:
Macro VGA_POS_SLEW_EN.
- Defined: on each strobe, each axis moves from its current output toward the shadow target by min(|target-current|, SLEW_STEP). Multiple frames may be needed to arrive; digits are unaffected.
- Undefined: position jumps to the target on the first strobe, and SLEW_STEP is unused.

Decomposition:
- Package vga_overlay_pkg holds:
  - the FSM state enum (IDLE, CONV)
  - a bcd_digit_t 4-bit typedef
  - constants MAX_VAL=999 and DD_ITERS=10
- One sub-module, bcd_dd10: a sequential 10-bit double-dabble iterator with start/done and three digit outputs, instantiated once. The top owns the shadows, clamping, strobe detection and slew.

Test Plan:
- Reset release, no stimulus, then toggle vga_vs low -> point_x=461, point_y=190, digits 0/0/0, frame_commit pulses once; outputs unchanged.
- val_in=360 accepted at cycle 0 -> val_ready low cycles 1..10, high cycle 11; after next vs falling edge bai=3, shi=6, ge=0, overflow=0.
- val_in=1023 -> after commit bai=9, shi=9, ge=9, overflow=1; a later val_in=7 -> 0/0/7, overflow=0.
- pos_valid with (700,2) then (100,200) in the same frame -> commit shows 100/200; a frame with only (700,2) -> commit shows 629/10.
- Conversion completes on the exact strobe edge -> old digits remain this frame; new digits appear on the following strobe, with frame_commit pulsing both times.
- VGA_POS_SLEW_EN, SLEW_STEP=4, current x=461, target 470 -> point_x 465, 469, 470 on three successive strobes; reset asserted mid-CONV -> val_ready=1 after release, no stale digits committed.
